adc_chan_sequencer: RTL and testbench

//  Parametrised multi-channel ADC scan sequencer and result holder.
//  - Powers up the ADC and waits a settle time.
//  - Round-robins over the enabled channels with a one-hot select.
//  - Captures each conversion and flags out-of-window samples.
//  - Sits between the AST ADC macro and the ADC controller register block.

---
 rtl/adc_chan_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_adc_chan_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_chan_sequencer.sv
// Multi-channel ADC scan sequencer: power-up settle, round-robin one-hot select,
// per-channel result hold and window IRQ. Optional averaging under ADC_SEQ_AVG_EN.
module adc_chan_sequencer #(
    parameter int NumChannels  = 2,
    parameter int DataW        = 10,
    parameter int SettleCycles = 4
`ifdef ADC_SEQ_AVG_EN
    ,
    parameter int AvgLog2      = 2
`endif
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [NumChannels-1:0]       chan_mask_i,
    input  logic [DataW-1:0]             thresh_lo_i,
    input  logic [DataW-1:0]             thresh_hi_i,
    output logic                         adc_pd_o,
    output logic [NumChannels-1:0]       adc_chnsel_o,
    input  logic [DataW-1:0]             adc_d_i,
    input  logic                         adc_d_val_i,
    output logic [NumChannels*DataW-1:0] sample_o,
    output logic [NumChannels-1:0]       sample_valid_o,
    output logic                         irq_o,
    output logic [NumChannels-1:0]       irq_chan_o,
    output logic [1:0]                   dbg_state_o
);

    localparam int PtrW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PWRUP = 2'd1,
        ST_CONV  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Circular search for the first set mask bit starting at start (or start+1 if excl).
    function automatic logic [PtrW-1:0] f_find(input logic [NumChannels-1:0] mask,
                                               input logic [PtrW-1:0] start,
                                               input logic excl);
        logic [PtrW-1:0]        res;
        logic                   found;
        logic [NumChannels-1:0] sh;
        int                     idx;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < NumChannels; k++) begin
            idx = (int'(start) + k + (excl ? 1 : 0)) % NumChannels;
            sh  = mask >> idx;
            if (!found && sh[0]) begin
                res   = PtrW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    state_e                   r_state, w_state_nxt;
    logic [CntW-1:0]          r_cnt;
    logic [PtrW-1:0]          r_ptr, w_ptr_nxt;
    logic                     w_settle_done;
    logic                     w_sample_ok;
    logic                     w_accept;
    logic [DataW-1:0]         w_result;
    logic [DataW-1:0]         r_cap;
    logic [NumChannels-1:0]   r_cap_ch;
    logic                     r_upd;
    logic                     w_out_of_win;
    logic [NumChannels*DataW-1:0] r_sample, w_sample_nxt;
    logic [NumChannels-1:0]   r_valid;
    logic                     r_irq;
    logic [NumChannels-1:0]   r_irq_ch;

    assign w_settle_done = (r_cnt == CntW'(SettleCycles - 1));

`ifdef ADC_SEQ_AVG_EN
    localparam int AccW  = DataW + AvgLog2;
    localparam int AcntW = (AvgLog2 > 0) ? AvgLog2 : 1;

    logic [AccW-1:0]  r_acc;
    logic [AccW-1:0]  w_acc_sum;
    logic [AcntW-1:0] r_acnt;
    logic             w_last;

    assign w_acc_sum   = r_acc + AccW'(adc_d_i);
    assign w_last      = (AvgLog2 == 0) || (r_acnt == {AcntW{1'b1}});
    assign w_result    = DataW'(w_acc_sum >> AvgLog2);
    assign w_sample_ok = adc_d_val_i && w_last;

    // Accumulator lives only for the duration of one CONV visit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc  <= '0;
            r_acnt <= '0;
        end else if (r_state != ST_CONV || !enable_i) begin
            r_acc  <= '0;
            r_acnt <= '0;
        end else if (adc_d_val_i) begin
            if (w_last) begin
                r_acc  <= '0;
                r_acnt <= '0;
            end else begin
                r_acc  <= w_acc_sum;
                r_acnt <= r_acnt + 1'b1;
            end
        end
    end
`else
    assign w_result    = adc_d_i;
    assign w_sample_ok = adc_d_val_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= enable_i ? w_ptr_nxt : r_ptr;
            r_cnt   <= (r_state == ST_PWRUP && !w_settle_done) ? r_cnt + 1'b1 : '0;
        end
    end

    // adc_d_val_i is a 1-cycle pulse with no back-pressure; it counts only in CONV while enabled.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_accept     = 1'b0;
        adc_pd_o     = 1'b0;
        adc_chnsel_o = '0;
        case (r_state)
            ST_IDLE: begin
                adc_pd_o = 1'b1;
                if (enable_i && |chan_mask_i) w_state_nxt = ST_PWRUP;
            end
            ST_PWRUP: begin
                if (w_settle_done) begin
                    if (|chan_mask_i) begin
                        w_ptr_nxt   = f_find(chan_mask_i, r_ptr, 1'b0);
                        w_state_nxt = ST_CONV;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_CONV: begin
                adc_chnsel_o = NumChannels'(1) << r_ptr;
                if (w_sample_ok) begin
                    w_accept    = enable_i;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (|chan_mask_i) begin
                    w_ptr_nxt   = f_find(chan_mask_i, r_ptr, 1'b1);
                    w_state_nxt = ST_CONV;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!enable_i) w_state_nxt = ST_IDLE;
    end

    assign w_out_of_win = (r_cap < thresh_lo_i) || (r_cap > thresh_hi_i);

    always_comb begin
        w_sample_nxt = r_sample;
        for (int k = 0; k < NumChannels; k++) begin
            if (r_cap_ch[k]) w_sample_nxt[k*DataW +: DataW] = r_cap;
        end
    end

    // Capture on the accepting edge, publish one edge later with live thresholds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cap    <= '0;
            r_cap_ch <= '0;
            r_upd    <= 1'b0;
            r_sample <= '0;
            r_valid  <= '0;
            r_irq    <= 1'b0;
            r_irq_ch <= '0;
        end else begin
            r_upd <= w_accept;
            if (w_accept) begin
                r_cap    <= w_result;
                r_cap_ch <= adc_chnsel_o;
            end
            if (r_upd) begin
                r_sample <= w_sample_nxt;
                r_valid  <= r_valid | r_cap_ch;
                r_irq    <= w_out_of_win;
                r_irq_ch <= w_out_of_win ? r_cap_ch : '0;
            end else begin
                r_irq    <= 1'b0;
                r_irq_ch <= '0;
            end
        end
    end

    assign sample_o       = r_sample;
    assign sample_valid_o = r_valid;
    assign irq_o          = r_irq;
    assign irq_chan_o     = r_irq_ch;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_adc_chan_sequencer.sv
// Bench for adc_chan_sequencer: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural scan model.
module tb_adc_chan_sequencer;

    localparam int NCH    = 2;
    localparam int DW     = 10;
    localparam int SETTLE = 4;
`ifdef ADC_SEQ_AVG_EN
    localparam int AVGL   = 2;
`else
    localparam int AVGL   = 0;
`endif
    localparam int NAVG   = 1 << AVGL;

    logic                clk    = 1'b0;
    logic                rst_n  = 1'b0;
    logic                en     = 1'b0;
    logic [NCH-1:0]      mask   = '0;
    logic [DW-1:0]       lo     = '0;
    logic [DW-1:0]       hi     = '1;
    logic [DW-1:0]       d      = '0;
    logic                dval   = 1'b0;
    logic                pd;
    logic [NCH-1:0]      chnsel;
    logic [NCH*DW-1:0]   sample;
    logic [NCH-1:0]      svalid;
    logic                irq;
    logic [NCH-1:0]      irq_ch;
    logic [1:0]          dbg_state;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    adc_chan_sequencer #(
        .NumChannels (NCH),
        .DataW       (DW),
        .SettleCycles(SETTLE)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (en),
        .chan_mask_i   (mask),
        .thresh_lo_i   (lo),
        .thresh_hi_i   (hi),
        .adc_pd_o      (pd),
        .adc_chnsel_o  (chnsel),
        .adc_d_i       (d),
        .adc_d_val_i   (dval),
        .sample_o      (sample),
        .sample_valid_o(svalid),
        .irq_o         (irq),
        .irq_chan_o    (irq_ch),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DW-1:0]  exp_q[$];
    int             ch_q[$];
    bit             m_powered = 1'b0;
    bit             m_gap     = 1'b0;
    int             m_warm    = 0;
    int             m_sel     = -1;
    int             m_ptr     = 0;
    int             m_nsamp   = 0;
    int             m_sum     = 0;
    logic [DW-1:0]  m_sample[NCH];
    logic [NCH-1:0] m_valid   = '0;
    logic           m_irq     = 1'b0;
    logic [NCH-1:0] m_irq_ch  = '0;

    function automatic int first_set(input logic [NCH-1:0] msk, input int start, input int skip);
        logic [NCH-1:0] sh;
        for (int off = skip; off < skip + NCH; off++) begin
            int idx;
            idx = (start + off) % NCH;
            sh  = msk >> idx;
            if (sh[0]) return idx;
        end
        return start;
    endfunction

    task automatic model_step();
        logic [DW-1:0] v;
        int            c;
        if (!rst_n) begin
            exp_q.delete();
            ch_q.delete();
            m_powered = 0; m_gap = 0; m_warm = 0; m_sel = -1; m_ptr = 0;
            m_nsamp = 0; m_sum = 0; m_valid = '0; m_irq = 0; m_irq_ch = '0;
            for (int k = 0; k < NCH; k++) m_sample[k] = '0;
            return;
        end
        m_irq    = 1'b0;
        m_irq_ch = '0;
        if (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            c = ch_q.pop_front();
            m_sample[c] = v;
            m_valid     = m_valid | (NCH'(1) << c);
            if (v < lo || v > hi) begin
                m_irq    = 1'b1;
                m_irq_ch = NCH'(1) << c;
            end
        end
        if (!en) begin
            m_powered = 0; m_warm = 0; m_sel = -1; m_gap = 0; m_nsamp = 0; m_sum = 0;
        end else if (!m_powered) begin
            if (mask != 0) begin
                m_powered = 1;
                m_warm    = SETTLE;
            end
        end else if (m_warm > 0) begin
            m_warm--;
            if (m_warm == 0) begin
                if (mask == 0) m_powered = 0;
                else begin
                    m_ptr = first_set(mask, m_ptr, 0);
                    m_sel = m_ptr; m_nsamp = 0; m_sum = 0;
                end
            end
        end else if (m_sel >= 0) begin
            if (dval) begin
                m_sum += int'(d);
                m_nsamp++;
                if (m_nsamp == NAVG) begin
                    exp_q.push_back(DW'(m_sum / NAVG));
                    ch_q.push_back(m_sel);
                    m_sel = -1;
                    m_gap = 1;
                end
            end
        end else if (m_gap) begin
            m_gap = 0;
            if (mask == 0) m_powered = 0;
            else begin
                m_ptr = first_set(mask, m_ptr, 1);
                m_sel = m_ptr; m_nsamp = 0; m_sum = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_on && rst_n) begin
            logic [NCH*DW-1:0] e_sample;
            logic [NCH-1:0]    e_sel;
            for (int k = 0; k < NCH; k++) e_sample[k*DW +: DW] = m_sample[k];
            e_sel = (m_sel >= 0) ? (NCH'(1) << m_sel) : '0;
            chk("m_pd",     64'(pd),     64'(!m_powered));
            chk("m_chnsel", 64'(chnsel), 64'(e_sel));
            chk("m_sample", 64'(sample), 64'(e_sample));
            chk("m_valid",  64'(svalid), 64'(m_valid));
            chk("m_irq",    64'(irq),    64'(m_irq));
            chk("m_irq_ch", 64'(irq_ch), 64'(m_irq_ch));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Serve one CONV visit with NAVG pulses (val, val+inc, ...); check select timing around it.
    task automatic respond(input logic [DW-1:0] val, input int inc,
                           input logic [NCH-1:0] exp_sel, input logic [NCH-1:0] exp_next);
        int n = 0;
        while (chnsel == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL sel_timeout: got no chnsel expected %0h", exp_sel);
        end
        chk("sel", 64'(chnsel), 64'(exp_sel));
        dval = 1'b1;
        d    = val;
        for (int i = 0; i < NAVG; i++) begin
            @(negedge clk);
            if (i < NAVG - 1) begin
                chk("hold", 64'(chnsel), 64'(exp_sel));
                d = DW'(int'(val) + (i + 1) * inc);
            end
        end
        dval = 1'b0;
        chk("gap", 64'(chnsel), 64'(0));
        @(negedge clk);
        chk("next", 64'(chnsel), 64'(exp_next));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cycles(3);
        chk("rst_pd",     64'(pd),     64'(1));
        chk("rst_chnsel", 64'(chnsel), 64'(0));
        chk("rst_sample", 64'(sample), 64'(0));
        chk("rst_valid",  64'(svalid), 64'(0));
        chk("rst_irq",    64'(irq),    64'(0));
        rst_n  = 1'b1;
        chk_on = 1'b1;
        cycles(2);

        // basic scan and power-up timing
        en   = 1'b1;
        mask = 2'b11;
        @(negedge clk);
        chk("pd_drop", 64'(pd), 64'(0));
        cycles(3);
        chk("settle_sel0", 64'(chnsel), 64'(0));
        @(negedge clk);
        chk("first_sel", 64'(chnsel), 64'(2'b01));
        respond(10'h123, 0, 2'b01, 2'b10);
        respond(10'h045, 0, 2'b10, 2'b01);
        chk("t1_sample", 64'(sample), 64'({10'h045, 10'h123}));
        chk("t1_valid",  64'(svalid), 64'(2'b11));

        // window irq, inclusive high bound
        lo = 10'h100;
        hi = 10'h200;
        respond(10'h0FF, 0, 2'b01, 2'b10);
        chk("t2_irq",    64'(irq),    64'(1));
        chk("t2_irq_ch", 64'(irq_ch), 64'(2'b01));
        respond(10'h200, 0, 2'b10, 2'b01);
        chk("t2_noirq",  64'(irq),    64'(0));

        // single-channel mask re-selects the same channel
        mask = 2'b10;
        respond(10'h150, 0, 2'b01, 2'b10);
        respond(10'h151, 0, 2'b10, 2'b10);
        respond(10'h152, 0, 2'b10, 2'b10);

        // enable drop one cycle before data valid
        lo = '0;
        hi = '1;
        en = 1'b0;
        @(negedge clk);
        chk("t4_pd",  64'(pd),     64'(1));
        chk("t4_sel", 64'(chnsel), 64'(0));
        dval = 1'b1;
        d    = 10'h3FF;
        @(negedge clk);
        dval = 1'b0;
        chk("t4_irq", 64'(irq), 64'(0));
        @(negedge clk);
        chk("t4_sample", 64'(sample), 64'({10'h152, 10'h150}));

        // strays in IDLE and PWRUP, pointer resumes at/after channel 1
        dval = 1'b1;
        d    = 10'h2AA;
        cycles(3);
        dval = 1'b0;
        chk("t5_idle_sample", 64'(sample), 64'({10'h152, 10'h150}));
        mask = 2'b11;
        en   = 1'b1;
        @(negedge clk);
        dval = 1'b1;
        d    = 10'h3AA;
        cycles(2);
        dval = 1'b0;
        respond(10'h066, 0, 2'b10, 2'b01);
        chk("t5_sample", 64'(sample), 64'({10'h066, 10'h150}));

        // mask cleared mid-scan ends at the next GAP
        mask = 2'b00;
        respond(10'h077, 0, 2'b01, 2'b00);
        chk("t5_pd_idle", 64'(pd), 64'(1));
        chk("t5_sample2", 64'(sample), 64'({10'h066, 10'h077}));

`ifdef ADC_SEQ_AVG_EN
        mask = 2'b01;
        respond(10'd10, 1, 2'b01, 2'b01);
        chk("t6_avg", 64'(sample[DW-1:0]), 64'(11));
        chk("t6_irq", 64'(irq), 64'(0));
`endif

        // randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (en) begin
                if ($urandom_range(0, 99) == 0) en = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                en = 1'b1;
            end
            if ($urandom_range(0, 63) == 0) mask = NCH'($urandom_range(0, (1 << NCH) - 1));
            if ($urandom_range(0, 31) == 0) begin
                lo = DW'($urandom);
                hi = DW'($urandom);
            end
            if (chnsel != '0) dval = ($urandom_range(0, 3) == 0);
            else              dval = ($urandom_range(0, 19) == 0);
            d = DW'($urandom);
            @(negedge clk);
        end
        dval = 1'b0;
        cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
